// File: rtl/rv_fetch.sv
// Instruction fetch stage: one outstanding imem read, redirect/stall handling, F->D register.
// Define URV_FETCH_SKID_EN to keep a response that arrives under stall instead of re-reading it.
module rv_fetch #(
    parameter logic [31:0] g_RESET_VECTOR = 32'h00000000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    output logic [31:0] im_addr_o,
    output logic        im_rd_o,
    input  logic [31:0] im_data_i,
    input  logic        im_valid_i,
    input  logic        x_stall_i,
    input  logic        x_bra_i,
    input  logic [31:0] x_pc_bra_i,
    output logic [31:0] f_ir_o,
    output logic [31:0] f_pc_o,
    output logic        f_valid_o
);
    localparam logic [1:0]  S_ISSUE = 2'd0;
    localparam logic [1:0]  S_WAIT  = 2'd1;
    localparam logic [1:0]  S_DROP  = 2'd2;
    localparam logic [31:0] NOP     = 32'h00000013;

    logic [1:0]  state, state_nx;
    logic [31:0] ptr, ptr_nx, rsp_addr, rsp_addr_nx;
    logic [31:0] ir_nx, pc_nx;
    logic        valid_nx;
    logic        req;
    logic [31:0] req_addr;
    logic        stall;
    logic [31:0] target;
`ifdef URV_FETCH_SKID_EN
    logic [31:0] sk_ir, sk_pc, sk_ir_nx, sk_pc_nx;
    logic        sk_vld, sk_vld_nx;
`endif

    assign stall  = x_stall_i & f_valid_o;
    assign target = x_pc_bra_i & ~32'h3;

    always_comb begin
        state_nx    = state;
        ptr_nx      = ptr;
        rsp_addr_nx = rsp_addr;
        ir_nx       = f_ir_o;
        pc_nx       = f_pc_o;
        valid_nx    = f_valid_o;
        req         = 1'b0;
        req_addr    = ptr;
`ifdef URV_FETCH_SKID_EN
        sk_ir_nx    = sk_ir;
        sk_pc_nx    = sk_pc;
        sk_vld_nx   = sk_vld;
`endif
        if (x_bra_i) begin
            valid_nx = 1'b0;
            ptr_nx   = target;
`ifdef URV_FETCH_SKID_EN
            sk_vld_nx = 1'b0;
`endif
            // Nothing left in flight: bypass the target straight onto the bus.
            if (state == S_ISSUE || im_valid_i) begin
                req         = 1'b1;
                req_addr    = target;
                rsp_addr_nx = target;
                ptr_nx      = target + 32'd4;
                state_nx    = S_WAIT;
            end else begin
                state_nx = S_DROP;
            end
        end else begin
            case (state)
                S_ISSUE: begin
                    if (!stall) begin
`ifdef URV_FETCH_SKID_EN
                        if (sk_vld) begin
                            ir_nx     = sk_ir;
                            pc_nx     = sk_pc;
                            valid_nx  = 1'b1;
                            sk_vld_nx = 1'b0;
                        end else begin
                            valid_nx = 1'b0;
                        end
`else
                        valid_nx = 1'b0;
`endif
                        req         = 1'b1;
                        rsp_addr_nx = ptr;
                        ptr_nx      = ptr + 32'd4;
                        state_nx    = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (im_valid_i) begin
                        if (!stall) begin
                            ir_nx       = im_data_i;
                            pc_nx       = rsp_addr;
                            valid_nx    = 1'b1;
                            req         = 1'b1;
                            rsp_addr_nx = ptr;
                            ptr_nx      = ptr + 32'd4;
                        end else begin
`ifdef URV_FETCH_SKID_EN
                            sk_ir_nx  = im_data_i;
                            sk_pc_nx  = rsp_addr;
                            sk_vld_nx = 1'b1;
`else
                            ptr_nx = rsp_addr;  // refetch this word after the stall
`endif
                            state_nx = S_ISSUE;
                        end
                    end else if (!stall) begin
                        valid_nx = 1'b0;
                    end
                end
                S_DROP: begin
                    if (!stall) valid_nx = 1'b0;
                    if (im_valid_i) begin
                        req         = 1'b1;
                        rsp_addr_nx = ptr;
                        ptr_nx      = ptr + 32'd4;
                        state_nx    = S_WAIT;
                    end
                end
                default: state_nx = S_ISSUE;
            endcase
        end
    end

    // Gated by reset so the bus stays quiet while the core is held.
    assign im_rd_o   = req & rst_n_i;
    assign im_addr_o = req_addr;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state     <= S_ISSUE;
            ptr       <= g_RESET_VECTOR;
            rsp_addr  <= g_RESET_VECTOR;
            f_ir_o    <= NOP;
            f_pc_o    <= 32'd0;
            f_valid_o <= 1'b0;
`ifdef URV_FETCH_SKID_EN
            sk_ir     <= NOP;
            sk_pc     <= 32'd0;
            sk_vld    <= 1'b0;
`endif
        end else begin
            state     <= state_nx;
            ptr       <= ptr_nx;
            rsp_addr  <= rsp_addr_nx;
            f_ir_o    <= ir_nx;
            f_pc_o    <= pc_nx;
            f_valid_o <= valid_nx;
`ifdef URV_FETCH_SKID_EN
            sk_ir     <= sk_ir_nx;
            sk_pc     <= sk_pc_nx;
            sk_vld    <= sk_vld_nx;
`endif
        end
    end
endmodule

// File: tb/tb_rv_fetch.sv
// Directed bench for rv_fetch; imem model returns the address as data after 'lat' cycles.
module tb_rv_fetch;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] im_addr;
    logic        im_rd;
    logic [31:0] im_data;
    logic        im_valid;
    logic        stall;
    logic        bra;
    logic [31:0] pc_bra;
    logic [31:0] f_ir;
    logic [31:0] f_pc;
    logic        f_valid;

    int n_run  = 0;
    int n_fail = 0;

`ifdef URV_FETCH_SKID_EN
    localparam bit SK = 1'b1;
`else
    localparam bit SK = 1'b0;
`endif

    always #5 clk = ~clk;

    rv_fetch #(.g_RESET_VECTOR(32'h00000100)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .im_addr_o  (im_addr),
        .im_rd_o    (im_rd),
        .im_data_i  (im_data),
        .im_valid_i (im_valid),
        .x_stall_i  (stall),
        .x_bra_i    (bra),
        .x_pc_bra_i (pc_bra),
        .f_ir_o     (f_ir),
        .f_pc_o     (f_pc),
        .f_valid_o  (f_valid)
    );

    // Memory is not tied to the DUT reset, so a read can complete while the core is held.
    int          lat       = 1;
    int          pend_cnt  = 0;
    logic [31:0] pend_addr = 32'd0;
    always @(posedge clk) begin
        if (im_rd) begin
            pend_cnt  <= lat;
            pend_addr <= im_addr;
        end else if (pend_cnt > 0) begin
            pend_cnt <= pend_cnt - 1;
        end
    end
    assign im_valid = (pend_cnt == 1);
    assign im_data  = pend_addr;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    task automatic adv;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; bra = 1'b0; pc_bra = 32'd0;
        repeat (2) adv();
        smp();
        chk("rst_valid", {31'd0, f_valid}, 32'd0);
        chk("rst_ir", f_ir, 32'h00000013);
        chk("rst_pc", f_pc, 32'd0);
        chk("rst_rd", {31'd0, im_rd}, 32'd0);

        // reset release and steady one-cycle fetch
        adv(); rst_n = 1'b1;                               // cycle 0
        smp();
        chk("c0_rd", {31'd0, im_rd}, 32'd1);
        chk("c0_addr", im_addr, 32'h100);
        adv();                                             // cycle 1
        smp();
        chk("c1_valid", {31'd0, f_valid}, 32'd0);
        chk("c1_rd", {31'd0, im_rd}, 32'd1);
        chk("c1_addr", im_addr, 32'h104);
        adv();                                             // cycle 2
        smp();
        chk("c2_valid", {31'd0, f_valid}, 32'd1);
        chk("c2_pc", f_pc, 32'h100);
        chk("c2_ir", f_ir, 32'h100);
        chk("c2_addr", im_addr, 32'h108);

        // stall three cycles with 0x104 on the outputs
        adv(); stall = 1'b1;                               // cycle 3
        smp();
        chk("c3_pc", f_pc, 32'h104);
        chk("c3_rd", {31'd0, im_rd}, 32'd0);
        for (int c = 4; c <= 5; c++) begin
            adv();
            smp();
            chk("stall_pc", f_pc, 32'h104);
            chk("stall_valid", {31'd0, f_valid}, 32'd1);
            chk("stall_rd", {31'd0, im_rd}, 32'd0);
        end
        adv(); stall = 1'b0;                               // cycle 6
        smp();
        chk("c6_rd", {31'd0, im_rd}, 32'd1);
        chk("c6_addr", im_addr, SK ? 32'h10C : 32'h108);
        chk("c6_pc", f_pc, 32'h104);
        adv();                                             // cycle 7
        smp();
        chk("c7_valid", {31'd0, f_valid}, SK ? 32'd1 : 32'd0);
        chk("c7_addr", im_addr, SK ? 32'h110 : 32'h10C);
        if (SK) chk("c7_pc", f_pc, 32'h108);

        // redirect during steady fetch
        adv(); bra = 1'b1; pc_bra = 32'h203;               // cycle 8
        smp();
        chk("c8_valid", {31'd0, f_valid}, 32'd1);
        chk("c8_pc", f_pc, SK ? 32'h10C : 32'h108);
        chk("c8_rd", {31'd0, im_rd}, 32'd1);
        chk("c8_addr", im_addr, 32'h200);
        adv(); bra = 1'b0;                                 // cycle 9
        smp();
        chk("c9_valid", {31'd0, f_valid}, 32'd0);
        chk("c9_addr", im_addr, 32'h204);
        adv(); lat = 4;                                    // cycle 10
        smp();
        chk("c10_valid", {31'd0, f_valid}, 32'd1);
        chk("c10_pc", f_pc, 32'h200);
        chk("c10_ir", f_ir, 32'h200);
        chk("c10_addr", im_addr, 32'h208);

        // redirect with a slow read in flight -> stale word must be dropped
        adv(); bra = 1'b1; pc_bra = 32'h300;               // cycle 11
        smp();
        chk("c11_pc", f_pc, 32'h204);
        chk("c11_rd", {31'd0, im_rd}, 32'd0);
        adv(); bra = 1'b0;
        for (int c = 12; c <= 13; c++) begin
            smp();
            chk("drop_valid", {31'd0, f_valid}, 32'd0);
            chk("drop_rd", {31'd0, im_rd}, 32'd0);
            adv();
        end
        lat = 1;                                           // cycle 14
        smp();
        chk("c14_rd", {31'd0, im_rd}, 32'd1);
        chk("c14_addr", im_addr, 32'h300);
        chk("c14_valid", {31'd0, f_valid}, 32'd0);
        adv();                                             // cycle 15
        smp();
        chk("c15_valid", {31'd0, f_valid}, 32'd0);
        chk("c15_addr", im_addr, 32'h304);

        // pointer wrap
        adv(); bra = 1'b1; pc_bra = 32'hFFFFFFFE;          // cycle 16
        smp();
        chk("c16_pc", f_pc, 32'h300);
        chk("c16_ir", f_ir, 32'h300);
        chk("c16_addr", im_addr, 32'hFFFFFFFC);
        adv(); bra = 1'b0;                                 // cycle 17
        smp();
        chk("c17_rd", {31'd0, im_rd}, 32'd1);
        chk("c17_addr", im_addr, 32'h0);
        adv();                                             // cycle 18
        smp();
        chk("c18_pc", f_pc, 32'hFFFFFFFC);
        chk("c18_addr", im_addr, 32'h4);
        adv(); lat = 4;                                    // cycle 19
        smp();
        chk("c19_pc", f_pc, 32'h0);
        chk("c19_valid", {31'd0, f_valid}, 32'd1);
        chk("c19_addr", im_addr, 32'h8);

        // reset mid-read; the late response lands while reset is held
        adv();                                             // cycle 20
        smp(); rst_n = 1'b0; lat = 1;
        #1;
        chk("mrst_valid", {31'd0, f_valid}, 32'd0);
        chk("mrst_ir", f_ir, 32'h00000013);
        chk("mrst_pc", f_pc, 32'd0);
        chk("mrst_rd", {31'd0, im_rd}, 32'd0);
        repeat (4) adv();                                  // cycle 24
        smp();
        chk("c24_valid", {31'd0, f_valid}, 32'd0);
        chk("c24_rd", {31'd0, im_rd}, 32'd0);
        adv(); rst_n = 1'b1;                               // cycle 25
        smp();
        chk("c25_rd", {31'd0, im_rd}, 32'd1);
        chk("c25_addr", im_addr, 32'h100);
        adv();                                             // cycle 26
        smp();
        chk("c26_valid", {31'd0, f_valid}, 32'd0);
        adv();                                             // cycle 27
        smp();
        chk("c27_valid", {31'd0, f_valid}, 32'd1);
        chk("c27_pc", f_pc, 32'h100);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
